// File: rtl/stack_arbiter.sv
// Two-requester arbiter and sequencer for a single shared stack, with its own occupancy tracking.
// Define STACK_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module stack_arbiter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [WIDTH-1:0]      wdata0,
  input  logic [WIDTH-1:0]      wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  stk_clr_n,
  output logic                  stk_en,
  output logic                  stk_con,
  output logic [WIDTH-1:0]      stk_din,
  input  logic [WIDTH-1:0]      stk_dout
);

  localparam int unsigned          MAX_I = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  MAX   = MAX_I[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]  ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                op_q, op_d;
  logic                bad_q, bad_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                busy_q, busy_d;
  logic                stk_en_q, stk_en_d, stk_con_q, stk_con_d;
  logic [WIDTH-1:0]    stk_din_q, stk_din_d;
  logic                grant;
`ifdef STACK_ARB_RR_EN
  logic                rr_q, rr_d;
`endif

  // Registered outputs are computed from next-state values so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    bad_d   = bad_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    count_d = count_q;
    grant   = 1'b0;
`ifdef STACK_ARB_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
`ifdef STACK_ARB_RR_EN
          grant = (req0 && req1) ? ~rr_q : req1;
          rr_d  = grant;
`else
          grant = ~req0;
`endif
          win_d   = grant;
          op_d    = grant ? op1 : op0;
          wdata_d = grant ? wdata1 : wdata0;
          bad_d   = op_d ? (count_q == '0) : (count_q == MAX);
          state_d = bad_d ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        if (op_q) begin
          count_d = count_q - ONE;
          state_d = CAPTURE;
        end else begin
          count_d = count_q + ONE;
          state_d = ACK;
        end
      end
      CAPTURE: begin
        rdata_d = stk_dout;
        state_d = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stk_en_d  = (state_d == ISSUE);
    stk_con_d = stk_en_d & op_d;
    stk_din_d = stk_en_d ? wdata_d : '0;
    ack0_d    = (state_d == ACK) & ~win_d;
    ack1_d    = (state_d == ACK) & win_d;
    err0_d    = ack0_d & bad_d;
    err1_d    = ack1_d & bad_d;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      win_q     <= 1'b0;
      op_q      <= 1'b0;
      bad_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      count_q   <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      busy_q    <= 1'b0;
      stk_en_q  <= 1'b0;
      stk_con_q <= 1'b0;
      stk_din_q <= '0;
`ifdef STACK_ARB_RR_EN
      rr_q      <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      op_q      <= op_d;
      bad_q     <= bad_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      count_q   <= count_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      busy_q    <= busy_d;
      stk_en_q  <= stk_en_d;
      stk_con_q <= stk_con_d;
      stk_din_q <= stk_din_d;
`ifdef STACK_ARB_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign count     = count_q;
  assign full      = (count_q == MAX);
  assign empty     = (count_q == '0);
  assign busy      = busy_q;
  assign stk_clr_n = ~clr;
  assign stk_en    = stk_en_q;
  assign stk_con   = stk_con_q;
  assign stk_din   = stk_din_q;

endmodule
